// File: rtl/imem_boot_controller.sv
// Instruction memory port arbiter: streams a boot image in from the loader,
// then hands the memory read path to the core fetch until a reload request.
module imem_boot_controller #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned INST_WIDTH = 32,
    parameter int unsigned IMEM_DEPTH = 1024,
    parameter logic [INST_WIDTH-1:0] NOP_INSTR = INST_WIDTH'(32'h00000013)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ld_valid,
    input  logic [INST_WIDTH-1:0] ld_data,
    input  logic                  ld_last,
    output logic                  ld_ready,
    input  logic                  reload_req,
    input  logic [ADDR_WIDTH-1:0] cpu_pc,
    output logic [INST_WIDTH-1:0] cpu_instr,
    output logic                  cpu_hold,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [INST_WIDTH-1:0] mem_wdata,
    input  logic [INST_WIDTH-1:0] mem_rdata,
    output logic                  boot_done,
    output logic                  load_trunc,
    output logic                  pc_misalign,
    output logic [ADDR_WIDTH-1:0] word_count
);

    localparam int unsigned PTR_W = $clog2(IMEM_DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(IMEM_DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] WC_MAX = ADDR_WIDTH'(IMEM_DEPTH);

    typedef enum logic [0:0] {StLoad, StRun} state_e;

    state_e                  state_q;
    logic [PTR_W-1:0]        wr_ptr_q;
    logic [ADDR_WIDTH-1:0]   word_count_q;
    logic                    load_trunc_q;
    logic                    running;
    logic                    accept;
    logic                    at_end;

    assign running = (state_q == StRun);
    assign at_end  = (wr_ptr_q == LAST_PTR);

    always_comb begin
        ld_ready    = !running && !rst;
        accept      = ld_valid && ld_ready;
        mem_we      = accept;
        mem_wdata   = ld_data;
        mem_addr    = running ? {2'b00, cpu_pc[ADDR_WIDTH-1:2]} : ADDR_WIDTH'(wr_ptr_q);
        cpu_instr   = running ? mem_rdata : NOP_INSTR;
        cpu_hold    = !running;
        boot_done   = running;
        pc_misalign = running && (cpu_pc[1:0] != 2'b00);
        word_count  = word_count_q;
        load_trunc  = load_trunc_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StLoad;
            wr_ptr_q     <= '0;
            word_count_q <= '0;
            load_trunc_q <= 1'b0;
        end else begin
            case (state_q)
                StLoad: begin
                    // A reload wins over a coincident accept: the word is still
                    // written, but the image restarts from index 0.
                    if (reload_req) begin
                        wr_ptr_q     <= '0;
                        word_count_q <= '0;
                    end else if (accept) begin
                        if (!at_end) begin
                            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                        end
                        if (word_count_q != WC_MAX) begin
                            word_count_q <= word_count_q + ADDR_WIDTH'(1);
                        end
                        if (ld_last || at_end) begin
                            state_q <= StRun;
                        end
                        if (at_end && !ld_last) begin
                            load_trunc_q <= 1'b1;
                        end
                    end
                end
                StRun: begin
                    if (reload_req) begin
                        state_q      <= StLoad;
                        wr_ptr_q     <= '0;
                        word_count_q <= '0;
                        load_trunc_q <= 1'b0;
                    end
                end
                default: state_q <= StLoad;
            endcase
        end
    end

endmodule
